// File: rtl/fifo_sync_fwft.sv
// Single-clock FIFO with exact fill count, programmable almost flags, sticky error flags,
// synchronous flush and selectable standard or first-word-fall-through read.
module fifo_sync_fwft #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1,
  localparam int ADDR     = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Flush,
  input  logic [WIDTH-1:0] Data,
  input  logic             WrEn,
  input  logic             RdEn,
  output logic [WIDTH-1:0] Q,
  output logic             Empty,
  output logic             Full,
  output logic             AlmostEmpty,
  output logic             AlmostFull,
  output logic [ADDR:0]    Count,
  output logic             Overflow,
  output logic             Underflow
);

  localparam logic [ADDR:0] DEPTH_C = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0] AF_T    = (ADDR+1)'(AF_THRESH);
  localparam logic [ADDR:0] AE_T    = (ADDR+1)'(AE_THRESH);
  localparam logic          AF_RST  = (AF_THRESH == 0);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR:0]    wr_ptr, rd_ptr, cnt_nxt;
  logic             wr_acc, rd_acc, clr;

  assign clr     = Reset | Flush;
  assign wr_acc  = WrEn & ~Full;
  assign rd_acc  = RdEn & ~Empty;
  assign cnt_nxt = Count + {{ADDR{1'b0}}, wr_acc} - {{ADDR{1'b0}}, rd_acc};

  // Flags are registered from the next count so they are exact one cycle after each op.
  always_ff @(posedge Clk) begin
    if (clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      Count       <= '0;
      Empty       <= 1'b1;
      Full        <= 1'b0;
      AlmostEmpty <= 1'b1;
      AlmostFull  <= AF_RST;
      Overflow    <= 1'b0;
      Underflow   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      Count       <= cnt_nxt;
      Empty       <= (cnt_nxt == '0);
      Full        <= (cnt_nxt == DEPTH_C);
      AlmostEmpty <= (cnt_nxt <= AE_T);
      AlmostFull  <= (cnt_nxt >= AF_T);
      if (WrEn & Full)  Overflow  <= 1'b1;
      if (RdEn & Empty) Underflow <= 1'b1;
    end
  end

  // Storage is deliberately not cleared; stale words are unreachable once pointers reset.
  always_ff @(posedge Clk) begin
    if (!clr && wr_acc) mem[wr_ptr[ADDR-1:0]] <= Data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign Q = Empty ? '0 : mem[rd_ptr[ADDR-1:0]];
    end else begin : g_std
      logic [WIDTH-1:0] q_reg;
      always_ff @(posedge Clk) begin
        if (clr)         q_reg <= '0;
        else if (rd_acc) q_reg <= mem[rd_ptr[ADDR-1:0]];
      end
      assign Q = q_reg;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Directed bench: a standard-read and an FWFT instance share one stimulus stream.
module tb_fifo_sync_fwft;
  logic       Clk = 1'b0, Reset, Flush, WrEn, RdEn;
  logic [7:0] Data;
  logic [7:0] q0, q1;
  logic [2:0] c0, c1;
  logic e0, f0, ae0, af0, ov0, un0;
  logic e1, f1, ae1, af1, ov1, un1;
  int checks = 0, failures = 0;

  always #5 Clk = ~Clk;

  fifo_sync_fwft #(.WIDTH(8), .DEPTH(4), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)) dut0 (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .Data(Data), .WrEn(WrEn), .RdEn(RdEn),
    .Q(q0), .Empty(e0), .Full(f0), .AlmostEmpty(ae0), .AlmostFull(af0), .Count(c0),
    .Overflow(ov0), .Underflow(un0));

  fifo_sync_fwft #(.WIDTH(8), .DEPTH(4), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .Data(Data), .WrEn(WrEn), .RdEn(RdEn),
    .Q(q1), .Empty(e1), .Full(f1), .AlmostEmpty(ae1), .AlmostFull(af1), .Count(c1),
    .Overflow(ov1), .Underflow(un1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full status of the standard instance: count, empty, full, almost-empty, almost-full, ovf, unf.
  task automatic st0(input string tag, input int cnt, input logic e, f, ae, af, ov, un);
    chk({tag, ".count"}, 32'(c0), 32'(cnt));
    chk({tag, ".empty"}, 32'(e0), 32'(e));
    chk({tag, ".full"},  32'(f0), 32'(f));
    chk({tag, ".ae"},    32'(ae0), 32'(ae));
    chk({tag, ".af"},    32'(af0), 32'(af));
    chk({tag, ".ovf"},   32'(ov0), 32'(ov));
    chk({tag, ".unf"},   32'(un0), 32'(un));
  endtask

  // One clock of stimulus; outputs are stable for sampling when this returns.
  task automatic op(input logic w, r, input logic [7:0] d, input logic fl, rs);
    WrEn = w; RdEn = r; Data = d; Flush = fl; Reset = rs;
    @(posedge Clk); #1;
    WrEn = 0; RdEn = 0; Flush = 0; Reset = 0;
  endtask

  initial begin
    op(0, 0, 8'h00, 0, 1);
    st0("reset", 0, 1, 0, 1, 0, 0, 0);
    chk("reset.q0", 32'(q0), 0);
    chk("reset.q1", 32'(q1), 0);

    // Fill then drain in standard mode
    op(1, 0, 8'h11, 0, 0); st0("w1", 1, 0, 0, 1, 0, 0, 0);
    op(1, 0, 8'h22, 0, 0); st0("w2", 2, 0, 0, 0, 0, 0, 0);
    op(1, 0, 8'h33, 0, 0); st0("w3", 3, 0, 0, 0, 1, 0, 0);
    op(1, 0, 8'h44, 0, 0); st0("w4", 4, 0, 1, 0, 1, 0, 0);
    op(0, 1, 8'h00, 0, 0); chk("r1.q", 32'(q0), 32'h11); st0("r1", 3, 0, 0, 0, 1, 0, 0);
    op(0, 1, 8'h00, 0, 0); chk("r2.q", 32'(q0), 32'h22); st0("r2", 2, 0, 0, 0, 0, 0, 0);
    op(0, 1, 8'h00, 0, 0); chk("r3.q", 32'(q0), 32'h33); st0("r3", 1, 0, 0, 1, 0, 0, 0);
    op(0, 1, 8'h00, 0, 0); chk("r4.q", 32'(q0), 32'h44); st0("r4", 0, 1, 0, 1, 0, 0, 0);

    // Overflow, then full with simultaneous write and read
    op(1, 0, 8'h11, 0, 0); op(1, 0, 8'h22, 0, 0); op(1, 0, 8'h33, 0, 0); op(1, 0, 8'h44, 0, 0);
    op(1, 0, 8'h55, 0, 0); st0("ovf", 4, 0, 1, 0, 1, 1, 0);
    op(1, 1, 8'h77, 0, 0); chk("fullwr.q", 32'(q0), 32'h11); st0("fullwr", 3, 0, 0, 0, 1, 1, 0);
    op(0, 1, 8'h00, 0, 0); chk("rb2.q", 32'(q0), 32'h22);
    op(0, 1, 8'h00, 0, 0); chk("rb3.q", 32'(q0), 32'h33);
    op(0, 1, 8'h00, 0, 0); chk("rb4.q", 32'(q0), 32'h44); st0("rb4", 0, 1, 0, 1, 0, 1, 0);

    // Underflow, then empty with simultaneous write and read
    op(0, 1, 8'h00, 0, 0); chk("unf.q", 32'(q0), 32'h44); st0("unf", 0, 1, 0, 1, 0, 1, 1);
    op(1, 1, 8'hA5, 0, 0); chk("emptywr.q", 32'(q0), 32'h44); st0("emptywr", 1, 0, 0, 1, 0, 1, 1);
    op(0, 1, 8'h00, 0, 0); chk("rA5.q", 32'(q0), 32'hA5); chk("rA5.count", 32'(c0), 0);

    // Steady-state streaming across the pointer wrap
    op(0, 0, 8'h00, 0, 1); st0("reset2", 0, 1, 0, 1, 0, 0, 0); chk("reset2.q0", 32'(q0), 0);
    op(1, 0, 8'h01, 0, 0); op(1, 0, 8'h02, 0, 0);
    for (int i = 0; i < 10; i++) begin
      op(1, 1, 8'(3 + i), 0, 0);
      chk($sformatf("wrap%0d.q0", i), 32'(q0), 32'(1 + i));
      chk($sformatf("wrap%0d.q1", i), 32'(q1), 32'(2 + i));
      chk($sformatf("wrap%0d.count", i), 32'(c0), 2);
    end
    chk("wrap.ovf", 32'(ov0), 0); chk("wrap.unf", 32'(un0), 0);

    // Flush with a concurrent write at Count=3, Overflow=1
    op(1, 0, 8'h0D, 0, 0); op(1, 0, 8'h0E, 0, 0); op(1, 0, 8'hFF, 0, 0);
    op(0, 1, 8'h00, 0, 0); chk("preflush.q", 32'(q0), 32'h0B); st0("preflush", 3, 0, 0, 0, 1, 1, 0);
    op(1, 0, 8'h99, 1, 0); st0("flush", 0, 1, 0, 1, 0, 0, 0);
    chk("flush.q0", 32'(q0), 0); chk("flush.q1", 32'(q1), 0); chk("flush.e1", 32'(e1), 1);

    // Same again, cleared by Reset
    op(1, 0, 8'h01, 0, 0); op(1, 0, 8'h02, 0, 0); op(1, 0, 8'h03, 0, 0); op(1, 0, 8'h04, 0, 0);
    op(1, 0, 8'h05, 0, 0);
    op(0, 1, 8'h00, 0, 0); chk("prerst.q", 32'(q0), 32'h01); st0("prerst", 3, 0, 0, 0, 1, 1, 0);
    op(1, 0, 8'h99, 0, 1); st0("rstwr", 0, 1, 0, 1, 0, 0, 0); chk("rstwr.q0", 32'(q0), 0);

    // First-word-fall-through behaviour
    chk("fw0.q1", 32'(q1), 0);
    op(1, 0, 8'h5A, 0, 0); chk("fw1.e1", 32'(e1), 0); chk("fw1.q1", 32'(q1), 32'h5A);
    op(1, 0, 8'h6B, 0, 0); chk("fw2.q1", 32'(q1), 32'h5A); chk("fw2.c1", 32'(c1), 2);
    op(0, 1, 8'h00, 0, 0); chk("fw3.q1", 32'(q1), 32'h6B); chk("fw3.c1", 32'(c1), 1);
    op(0, 1, 8'h00, 0, 0); chk("fw4.e1", 32'(e1), 1); chk("fw4.q1", 32'(q1), 0);
    chk("fw4.unf1", 32'(un1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
